// File: rtl/jive_spi_master_if.sv
// p0/p1 I/O bus between the JiVe CPU and the SPI master: request in p0, registered reply in p1.
interface jive_spi_master_if;
    logic        csel;
    logic        rden;
    logic        wren;
    logic [1:0]  addr;
    logic [3:0]  bena;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        dtack;

    modport master (output csel, rden, wren, addr, bena, wdata, input rdata, dtack);
    modport slave  (input csel, rden, wren, addr, bena, wdata, output rdata, dtack);
endinterface

// File: rtl/jive_spi_master.sv
// Memory-mapped mode-0 SPI master: one byte per DATA write, MSB first, software-driven slave select.
module jive_spi_master #(
    parameter logic [7:0] CLK_DIV_RST = 8'd2
) (
    input  logic              clk,
    input  logic              rst_n,
    jive_spi_master_if.slave  bus,
    output logic              spi_ss_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
);
    typedef enum logic [1:0] {IDLE, LEAD, TRAIL} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, clkdiv, tx_shift, rx_shift, rx_byte;
    logic [2:0]  bit_cnt;
    logic        busy, rx_valid, ovr;
    logic        rd, wr, data_wr, start, phase_end, rise, fall, done;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign rd        = bus.csel & bus.rden;
    assign wr        = bus.csel & bus.wren;
    assign data_wr   = wr & (bus.addr == 2'd0) & bus.bena[0];
    assign start     = data_wr & (state == IDLE);
    assign phase_end = (cnt == clkdiv);
    assign unused_bits = ^{bus.wdata[31:9], bus.bena[3:2]};

    always_comb begin
        state_nxt = state;
        rise      = 1'b0;
        fall      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = LEAD;
            LEAD:  if (phase_end) begin
                       rise      = 1'b1;
                       state_nxt = TRAIL;
                   end
            TRAIL: if (phase_end) begin
                       fall = 1'b1;
                       if (bit_cnt == 3'd7) begin
                           done      = 1'b1;
                           state_nxt = IDLE;
                       end else begin
                           state_nxt = LEAD;
                       end
                   end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 32'h0;
        case (bus.addr)
            2'd0: rd_mux = {24'h0, rx_byte};
            2'd1: rd_mux = {23'h0, ~spi_ss_n, 5'h0, ovr, rx_valid, busy};
            2'd2: rd_mux = {24'h0, clkdiv};
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= 8'h0;
            clkdiv    <= CLK_DIV_RST;
            tx_shift  <= 8'h0;
            rx_shift  <= 8'h0;
            rx_byte   <= 8'h0;
            bit_cnt   <= 3'd0;
            busy      <= 1'b0;
            rx_valid  <= 1'b0;
            ovr       <= 1'b0;
            spi_ss_n  <= 1'b1;
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
            bus.dtack <= 1'b0;
            bus.rdata <= 32'h0;
        end else begin
            // Counter restarts at every half-period boundary and stays cleared while idle.
            if (state == IDLE || phase_end) cnt <= 8'h0;
            else                            cnt <= cnt + 8'd1;

            if (start) begin
                tx_shift <= bus.wdata[7:0];
                spi_mosi <= bus.wdata[7];
                bit_cnt  <= 3'd0;
                busy     <= 1'b1;
            end
            if (rise) begin
                spi_sclk <= 1'b1;
                rx_shift <= {rx_shift[6:0], spi_miso};
            end
            if (fall) begin
                spi_sclk <= 1'b0;
                bit_cnt  <= bit_cnt + 3'd1;
                tx_shift <= {tx_shift[6:0], 1'b0};
                if (!done) spi_mosi <= tx_shift[6];
            end
            if (done) begin
                busy    <= 1'b0;
                rx_byte <= rx_shift;
            end

            // Completion wins over a same-cycle DATA read so the fresh byte is not lost.
            if (done)                            rx_valid <= 1'b1;
            else if (rd && bus.addr == 2'd0)     rx_valid <= 1'b0;

            if (data_wr && busy)                 ovr <= 1'b1;
            else if (wr && bus.addr == 2'd1 && bus.bena[0] && bus.wdata[2]) ovr <= 1'b0;

            if (wr && bus.addr == 2'd1 && bus.bena[1]) spi_ss_n <= ~bus.wdata[8];
            if (wr && bus.addr == 2'd2 && bus.bena[0] && !busy) clkdiv <= bus.wdata[7:0];

            bus.dtack <= bus.csel & (bus.rden | bus.wren);
            bus.rdata <= rd ? rd_mux : 32'h0;
        end
    end
endmodule

// File: tb/tb_jive_spi_master.sv
// Randomized bench for jive_spi_master with an SPI slave model and a register-level reference model.
module tb_jive_spi_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_ss_n, spi_sclk, spi_mosi;
    logic spi_miso = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // reference model of the register-visible state
    logic [7:0] m_div = 8'd2;
    logic [7:0] m_rx = 8'h0;
    logic       m_ss = 1'b0, m_ovr = 1'b0, m_rxv = 1'b0;

    jive_spi_master_if bus();

    jive_spi_master #(.CLK_DIV_RST(8'd2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .spi_ss_n(spi_ss_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {23'h0, m_ss, 5'h0, m_ovr, m_rxv, 1'b0};
    endfunction

    task automatic bus_idle();
        bus.csel = 0; bus.rden = 0; bus.wren = 0; bus.addr = 0; bus.bena = 0; bus.wdata = 0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.csel = 1; bus.wren = 1; bus.rden = 0; bus.addr = a; bus.bena = be; bus.wdata = d;
        @(posedge clk); #1;
        chk("wr_dtack", {31'h0, bus.dtack}, 32'h1);
        bus_idle();
    endtask

    task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.csel = 1; bus.rden = 1; bus.wren = 0; bus.addr = a;
        @(posedge clk); #1;
        chk({tag, "_dtack"}, {31'h0, bus.dtack}, 32'h1);
        chk(tag, bus.rdata, exp);
        bus_idle();
        if (a == 2'd0) m_rxv = 1'b0;
    endtask

    // poll: 1 = STATUS read every cycle, 0 = DATA read every cycle, -1 = no reads.
    // inj >= 0 puts a second DATA write on that loop iteration.
    task automatic run_xfer(input logic [7:0] tx, input logic [7:0] mb, input int poll, input int inj);
        int n = 16 * (int'(m_div) + 1);
        int per = int'(m_div) + 1;
        int it = 0, rises = 0, falls = 0, busyc = 0, badrun = 0, badold = 0, hrun = 0, lrun = 0;
        logic [7:0] cap = 8'h0;
        logic [7:0] old = m_rx;
        logic prev = 1'b0, fin = 1'b0, extra = 1'b0;
        spi_miso = mb[7];
        bus.csel = 1; bus.wren = 1; bus.addr = 0; bus.bena = 4'h1; bus.wdata = {24'h0, tx};
        @(posedge clk); #1;
        bus_idle();
        if (poll >= 0) begin bus.csel = 1; bus.rden = 1; bus.addr = poll[1:0]; end
        while (!fin && it < n + 20) begin
            if (it == inj) begin
                bus.rden = 0; bus.wren = 1; bus.addr = 0; bus.bena = 4'h1; bus.wdata = 32'h34;
            end
            @(posedge clk); #1;
            if (it == inj) begin
                bus.wren = 0; bus.bena = 0; bus.wdata = 0; bus.rden = 1; bus.addr = poll[1:0];
            end
            it++;
            if (poll == 1 && bus.dtack && bus.rdata[0]) busyc++;
            if (poll == 0 && bus.rdata !== {24'h0, old}) badold++;
            if (spi_sclk && !prev) begin
                rises++;
                cap = {cap[6:0], spi_mosi};
                if (rises > 1 && lrun != per) badrun++;
                hrun = 1;
            end else if (!spi_sclk && prev) begin
                falls++;
                if (hrun != per) badrun++;
                lrun = 1;
                if (falls < 8) spi_miso = mb[7 - falls];
            end else if (spi_sclk) hrun++;
            else lrun++;
            prev = spi_sclk;
            if (falls == 8) begin
                if (poll != 1 || extra) fin = 1'b1;
                extra = 1'b1;
            end
        end
        bus_idle();
        chk("xfer_done", {31'h0, fin}, 32'h1);
        chk("sclk_pulses", rises, 8);
        chk("mosi_byte", {24'h0, cap}, {24'h0, tx});
        chk("sclk_halfperiods", badrun, 0);
        if (poll == 1) chk("busy_cycles", busyc, (inj >= 0) ? n - 1 : n);
        if (poll == 0) chk("old_rx_during_xfer", badold, 0);
        m_rx = mb;
        m_rxv = 1'b1;
        if (inj >= 0) m_ovr = 1'b1;
    endtask

    task automatic model_reset();
        m_div = 8'd2; m_rx = 8'h0; m_ss = 1'b0; m_ovr = 1'b0; m_rxv = 1'b0;
    endtask

    initial begin
        logic [7:0] t, r;
        int rises;
        logic prev;
        bus_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_ss_n", {31'h0, spi_ss_n}, 32'h1);
        chk("rst_sclk", {31'h0, spi_sclk}, 32'h0);
        chk("rst_mosi", {31'h0, spi_mosi}, 32'h0);
        chk("rst_dtack", {31'h0, bus.dtack}, 32'h0);
        bus_read("rst_status", 2'd1, 32'h0);
        bus_read("rst_clkdiv", 2'd2, 32'h2);
        bus_read("rst_data", 2'd0, 32'h0);
        bus_read("reg3", 2'd3, 32'h0);

        // CLKDIV=0, SS asserted, A5 out / 3C in
        bus_write(2'd2, 4'h1, 32'h0); m_div = 8'd0;
        bus_write(2'd1, 4'h3, 32'h100); m_ss = 1'b1;
        chk("ss_asserted", {31'h0, spi_ss_n}, 32'h0);
        run_xfer(8'hA5, 8'h3C, 1, -1);
        bus_read("status_after_a5", 2'd1, exp_status());
        bus_read("data_3c", 2'd0, {24'h0, m_rx});
        bus_read("status_after_read", 2'd1, exp_status());

        // CLKDIV=3, FF out
        bus_write(2'd2, 4'h1, 32'h3); m_div = 8'd3;
        bus_read("clkdiv3", 2'd2, 32'h3);
        r = 8'($urandom);
        run_xfer(8'hFF, r, 1, -1);
        bus_read("data_ff_rx", 2'd0, {24'h0, m_rx});

        // overrun: second DATA write mid-transfer is dropped
        bus_write(2'd2, 4'h1, 32'h0); m_div = 8'd0;
        run_xfer(8'h12, 8'hC3, 1, 6);
        bus_read("status_ovr", 2'd1, exp_status());
        bus_write(2'd1, 4'h1, 32'h4); m_ovr = 1'b0;
        bus_read("status_ovr_clr", 2'd1, exp_status());

        // DATA read on every cycle incl. the completion cycle
        bus_write(2'd2, 4'h1, 32'h1); m_div = 8'd1;
        run_xfer(8'($urandom), 8'($urandom), 0, -1);
        bus_read("status_rxv_kept", 2'd1, exp_status());
        bus_read("data_after_poll", 2'd0, {24'h0, m_rx});

        // random transfers with random divider; rx overwritten without a flag
        for (int k = 0; k < 4; k++) begin
            m_div = 8'($urandom_range(0, 3));
            bus_write(2'd2, 4'h1, {24'h0, m_div});
            t = 8'($urandom); r = 8'($urandom);
            run_xfer(t, r, (k % 2 == 0) ? 1 : -1, -1);
            bus_read("rand_status", 2'd1, exp_status());
        end
        bus_read("rand_data", 2'd0, {24'h0, m_rx});

        // csel low / strobes low: no ack, zero data, no side effects
        run_xfer(8'h5A, 8'h99, -1, -1);
        bus.csel = 0; bus.rden = 1; bus.addr = 0;
        @(posedge clk); #1;
        chk("nosel_dtack", {31'h0, bus.dtack}, 32'h0);
        chk("nosel_rdata", bus.rdata, 32'h0);
        bus.csel = 1; bus.rden = 0; bus.wren = 0; bus.addr = 1; bus.bena = 4'hF; bus.wdata = 32'h0;
        @(posedge clk); #1;
        chk("nostrobe_dtack", {31'h0, bus.dtack}, 32'h0);
        bus_idle();
        bus_read("nosel_status", 2'd1, exp_status());

        // reset during the 5th SCLK pulse
        bus_write(2'd2, 4'h1, 32'h1); m_div = 8'd1;
        bus.csel = 1; bus.wren = 1; bus.addr = 0; bus.bena = 4'h1; bus.wdata = 32'hE7;
        @(posedge clk); #1;
        bus_idle();
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 200 && rises < 5; i++) begin
            @(posedge clk); #1;
            if (spi_sclk && !prev) rises++;
            prev = spi_sclk;
        end
        chk("reached_5th_sclk", rises, 5);
        rst_n = 0;
        @(posedge clk); #1;
        chk("midrst_sclk", {31'h0, spi_sclk}, 32'h0);
        chk("midrst_ss_n", {31'h0, spi_ss_n}, 32'h1);
        chk("midrst_mosi", {31'h0, spi_mosi}, 32'h0);
        rst_n = 1;
        model_reset();
        bus_read("midrst_status", 2'd1, 32'h0);
        bus_read("midrst_clkdiv", 2'd2, 32'h2);
        t = 8'($urandom); r = 8'($urandom);
        run_xfer(t, r, 1, -1);
        bus_read("post_rst_status", 2'd1, exp_status());
        bus_read("post_rst_data", 2'd0, {24'h0, m_rx});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
